mem_stage_lsu: RTL
==================

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

Interface
REQ-001 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be, as name direction width meaning (clock and reset first):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- ex_valid  in  1  EX/MEM register holds a valid instruction
- memread, memwrite  in  1 each  load or store request from the EX/MEM register
- funct3  in  3  RISC-V access size/sign
- aluout  in  32  byte address
- writedata  in  32  store data
- pipe_hold  in  1  downstream pipeline frozen by the hazard unit
- readdata  out  32  formatted load result, feeding the MEM/WB register
- mem_stall  out  1  freeze the pipeline
- mem_err  out  1  misaligned access or illegal funct3
- dmem_req, dmem_we  out  1 each  memory request and write enable
- dmem_addr  out  32  word address, {aluout[31:2], 2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  raw read word

Function
REQ-003 States SHALL be IDLE, REQ, WAIT and DONE.
REQ-004 An operation SHALL start in IDLE when ex_valid & (memread | memwrite) & !mem_err. At that point dmem_req=1 in the same cycle, and addr, we, funct3 and wdata are latched.
REQ-005 In REQ, dmem_* outputs SHALL come only from the latched registers and stay stable until dmem_gnt; ex_valid changes SHALL be ignored.
REQ-006 On dmem_gnt:
- a write SHALL complete that cycle;
- a read SHALL go to WAIT, with dmem_rvalid accepted no earlier than the next cycle.
REQ-007 In WAIT, dmem_rvalid SHALL complete the read, and the formatted data SHALL be written to rdata_q.
REQ-008 In the completion cycle: mem_stall=0; readdata = formatted dmem_rdata (bypass, 0 latency); next state is DONE if pipe_hold=1, otherwise IDLE.
REQ-009 DONE SHALL hold mem_stall=0, readdata=rdata_q, dmem_req=0, and return to IDLE when pipe_hold=0; no reissue of the same op SHALL occur.
REQ-010 mem_stall SHALL be 1 in every cycle from issue until, but excluding, the completion cycle; otherwise 0.
REQ-011 funct3 encodings SHALL be 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU; any other encoding, or 100/101 with memwrite, SHALL be illegal.
REQ-012 Misalignment SHALL be halfword with aluout[0]=1, or word with aluout[1:0]!=0.
REQ-013 On mem_err there SHALL be no request, mem_stall=0, readdata=0, with mem_err asserted combinationally while ex_valid is high.
REQ-014 Store lanes SHALL be: SB be=4'b0001<<a[1:0], wdata={4{wd[7:0]}}; SH be=4'b0011<<{a[1],1'b0}, wdata={2{wd[15:0]}}; SW be=4'hF.
REQ-015 Loads SHALL select the lane by latched a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-016 dmem_rvalid outside WAIT, and dmem_gnt without a request, SHALL be ignored.
REQ-017 With memread and memwrite both high, the access SHALL be treated as a write.
REQ-018 readdata SHALL be 0 in IDLE with no completion and for writes.

Reset
REQ-019 reset SHALL force IDLE and clear rdata_q and all latched op registers.
REQ-020 During reset: dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, readdata=0, mem_stall=0, mem_err=0.
REQ-021 Reset mid-operation SHALL abandon the transaction; a late dmem_rvalid after reset SHALL be ignored (REQ-016).

Structure
REQ-022 Package lsu_pkg SHALL hold the funct3 constants and the lsu_state_t enum.
REQ-023 Sub-module lsu_align (combinational) SHALL hold store lane alignment, byte enables and load extraction/extension; the FSM lives in mem_stage_lsu.

Verification
REQ-024 The bench SHALL cover:
- LW 0x100, gnt same cycle, rvalid next with 0xDEADBEEF -> 1 stall cycle; readdata=0xDEADBEEF at completion.
- LB 0x103, rdata 0x80123456 -> readdata=0xFFFFFF80; LBU -> 0x00000080; LHU 0x102 -> 0x00008012.
- SH 0x202, writedata 0x0000ABCD, gnt delayed 3 cycles -> req/addr 0x200/be 4'b1100/wdata 0xABCDABCD stable 3 cycles, stall 3 cycles.
- LW 0x101 -> mem_err=1, dmem_req=0, stall=0; funct3=011 -> mem_err=1.
- LW completing with pipe_hold=1 for 2 cycles -> DONE; readdata held; no second dmem_req; IDLE after hold drops.
- reset in WAIT, then rvalid -> state IDLE, all outputs 0, rvalid ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants, state encoding and access-legality helpers for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NBYTES = XLEN / 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_t;

  // Unsigned variants only exist for loads.
  function automatic logic f3_illegal(input logic [2:0] f3, input logic is_store);
    logic ill;
    case (f3)
      F3_B, F3_H, F3_W: ill = 1'b0;
      F3_BU, F3_HU:     ill = is_store;
      default:          ill = 1'b1;
    endcase
    return ill;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a_lo);
    logic mis;
    case (f3)
      F3_H, F3_HU: mis = a_lo[0];
      F3_W:        mis = |a_lo;
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables and replicated store data,
// plus load lane extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [XLEN-1:0]   st_data_i,
  input  logic [XLEN-1:0]   ld_word_i,
  output logic [NBYTES-1:0] be_o,
  output logic [XLEN-1:0]   st_lanes_o,
  output logic [XLEN-1:0]   ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Stores replicate the datum across lanes so the enables alone pick the target bytes.
  always_comb begin : store_lanes
    be_o       = '0;
    st_lanes_o = st_data_i;
    case (funct3_i[1:0])
      2'b00: begin
        be_o       = 4'b0001 << addr_lo_i;
        st_lanes_o = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << {addr_lo_i[1], 1'b0};
        st_lanes_o = {2{st_data_i[15:0]}};
      end
      default: begin
        be_o       = 4'hF;
        st_lanes_o = st_data_i;
      end
    endcase
  end

  always_comb begin : load_lanes
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'd0:    byte_sel = ld_word_i[7:0];
      2'd1:    byte_sel = ld_word_i[15:8];
      2'd2:    byte_sel = ld_word_i[23:16];
      default: byte_sel = ld_word_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];

    ld_data_o = ld_word_i;
    case (funct3_i)
      F3_B:    ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data_o = {24'h000000, byte_sel};
      F3_H:    ld_data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data_o = {16'h0000, half_sel};
      default: ld_data_o = ld_word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one data-memory access per instruction,
// stalls the pipeline until completion and formats load data for MEM/WB.
module mem_stage_lsu
  import lsu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   aluout,
  input  logic [XLEN-1:0]   writedata,
  input  logic              pipe_hold,
  output logic [XLEN-1:0]   readdata,
  output logic              mem_stall,
  output logic              mem_err,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [NBYTES-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata
);

  lsu_state_t state_q, state_d;

  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      funct3_q;
  logic            we_q;

  logic access_c;
  logic bad_c;
  logic idle_c;
  logic start_c;
  logic latch_c;

  logic [2:0]        al_funct3;
  logic [1:0]        al_addr_lo;
  logic [XLEN-1:0]   al_st_data;
  logic [NBYTES-1:0] al_be;
  logic [XLEN-1:0]   al_st_lanes;
  logic [XLEN-1:0]   al_ld_data;

  assign access_c = ex_valid & (memread | memwrite);
  assign bad_c    = f3_illegal(funct3, memwrite) | misaligned(funct3, aluout[1:0]);
  assign idle_c   = (state_q == IDLE);
  assign start_c  = access_c & ~bad_c & idle_c & ~reset;
  assign mem_err  = access_c & bad_c & idle_c & ~reset;

  // In IDLE the issue cycle steers the live EX/MEM fields; afterwards only the latched copy.
  assign al_funct3  = idle_c ? funct3       : funct3_q;
  assign al_addr_lo = idle_c ? aluout[1:0]  : addr_q[1:0];
  assign al_st_data = idle_c ? writedata    : wdata_q;

  lsu_align u_align (
    .funct3_i   (al_funct3),
    .addr_lo_i  (al_addr_lo),
    .st_data_i  (al_st_data),
    .ld_word_i  (dmem_rdata),
    .be_o       (al_be),
    .st_lanes_o (al_st_lanes),
    .ld_data_o  (al_ld_data)
  );

  always_ff @(posedge clk) begin : state_reg
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin : op_regs
    if (reset) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rdata_q <= rdata_d;
      if (latch_c) begin
        addr_q   <= aluout;
        wdata_q  <= writedata;
        funct3_q <= funct3;
        we_q     <= memwrite;
      end
    end
  end

  // Reset drives every output low regardless of state; completion never stalls.
  always_comb begin : fsm_comb
    state_d    = state_q;
    rdata_d    = rdata_q;
    latch_c    = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_be    = '0;
    dmem_wdata = '0;
    mem_stall  = 1'b0;
    readdata   = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (start_c) begin
            latch_c    = 1'b1;
            dmem_req   = 1'b1;
            dmem_we    = memwrite;
            dmem_addr  = {aluout[XLEN-1:2], 2'b00};
            dmem_be    = al_be;
            dmem_wdata = al_st_lanes;
            if (dmem_gnt && memwrite) begin
              rdata_d = '0;
              state_d = pipe_hold ? DONE : IDLE;
            end else begin
              mem_stall = 1'b1;
              state_d   = dmem_gnt ? WAIT : REQ;
            end
          end
        end
        REQ: begin
          dmem_req   = 1'b1;
          dmem_we    = we_q;
          dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
          dmem_be    = al_be;
          dmem_wdata = al_st_lanes;
          if (dmem_gnt && we_q) begin
            rdata_d = '0;
            state_d = pipe_hold ? DONE : IDLE;
          end else begin
            mem_stall = 1'b1;
            if (dmem_gnt) begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid) begin
            readdata = al_ld_data;
            rdata_d  = al_ld_data;
            state_d  = pipe_hold ? DONE : IDLE;
          end else begin
            mem_stall = 1'b1;
          end
        end
        DONE: begin
          readdata = rdata_q;
          if (!pipe_hold) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
